// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// fetch_queue uses the optional static backward-taken predictor only when FETCH_QUEUE_BTFN_EN is defined.
package fetch_pkg;

    localparam logic [31:0] HALT_INSTR = 32'h000f0033;
    localparam logic [31:0] NOP_INSTR  = 32'h00000013;
    localparam logic [4:0]  OP_BRANCH  = 5'b11000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred_taken;
    } fq_entry_t;

    function automatic logic [31:0] b_imm(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    // A branch with a negative offset is assumed to close a loop, so it is predicted taken.
    function automatic logic is_back_branch(input logic [31:0] instr);
        return (instr[6:2] == OP_BRANCH) && instr[31];
    endfunction

endpackage

// File: rtl/fq_fifo.sv
// Circular buffer of fetched {pc, instr, pred_taken} entries with head/tail/count tracking.
// A flush empties the buffer and overrides any simultaneous push or pop.
module fq_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic                     flush,
    input  logic                     push,
    input  fq_entry_t                push_data,
    input  logic                     pop,
    output fq_entry_t                head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fq_entry_t      mem [DEPTH];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic           do_push;
    logic           do_pop;

    assign do_push   = push && !flush;
    assign do_pop    = pop && (count != '0) && !flush;
    assign head_data = mem[head];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (ce) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (do_push) tail <= tail + PW'(1);
                if (do_pop)  head <= head + PW'(1);
                case ({do_push, do_pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage has no reset; the top masks the head entry whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (rst_n && ce && do_push) begin
            mem[tail] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch stage: sequential fetch into a DEPTH-entry FIFO feeding ID.
// Define FETCH_QUEUE_BTFN_EN to enable static backward-taken branch prediction.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          AW       = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    output logic                     imem_req,
    output logic [AW-1:0]            imem_addr,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [31:0]              deq_pc,
    output logic [31:0]              deq_instr,
    output logic                     deq_pred_taken,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   occupancy
);

    logic [31:0]  fetch_pc;
    logic [31:0]  req_pc;
    logic [31:0]  rsp_pc;
    logic         rsp_valid;
    logic         halt_hit;
    logic         pred_hit;
    logic [31:0]  pred_target;
    logic         kill;
    logic         issue;
    logic [$clog2(DEPTH):0] count;
    fq_entry_t    push_entry;
    fq_entry_t    head_entry;

    assign halt_hit = rsp_valid && (imem_rdata == HALT_INSTR);

`ifdef FETCH_QUEUE_BTFN_EN
    assign pred_hit    = rsp_valid && is_back_branch(imem_rdata);
    assign pred_target = rsp_pc + b_imm(imem_rdata);
`else
    assign pred_hit    = 1'b0;
    assign pred_target = rsp_pc;
`endif

    // Anything that changes the fetch stream drops the response still in flight.
    assign kill = redirect || halt_hit || pred_hit;

    // Credit counts the pushing response and the outstanding request; a same-cycle pop is not credited.
    assign issue = !halted && !kill &&
                   ((int'(count) + int'(rsp_valid) + int'(imem_req)) < DEPTH);

    assign push_entry = '{pc: rsp_pc, instr: imem_rdata, pred_taken: pred_hit};

    fq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .flush     (redirect),
        .push      (rsp_valid),
        .push_data (push_entry),
        .pop       (deq_ready),
        .head_data (head_entry),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc  <= RESET_PC;
            req_pc    <= '0;
            rsp_pc    <= '0;
            rsp_valid <= 1'b0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            halted    <= 1'b0;
        end else if (ce) begin
            rsp_valid <= imem_req && !kill;
            rsp_pc    <= req_pc;
            imem_req  <= issue;
            if (issue) begin
                imem_addr <= fetch_pc[AW+1:2];
                req_pc    <= fetch_pc;
            end
            if (redirect) begin
                fetch_pc <= redirect_pc & ~32'h3;
                halted   <= 1'b0;
            end else begin
                if (halt_hit) halted <= 1'b1;
                if (pred_hit) begin
                    fetch_pc <= pred_target;
                end else if (issue) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
            end
        end
    end

    assign deq_valid      = (count != '0);
    assign deq_pc         = deq_valid ? head_entry.pc : 32'h0;
    assign deq_instr      = deq_valid ? head_entry.instr : NOP_INSTR;
    assign deq_pred_taken = deq_valid && head_entry.pred_taken;
    assign occupancy      = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: startup latency, back-pressure, redirect, halt, clock enable
// and (with FETCH_QUEUE_BTFN_EN) backward-branch prediction against a 1-cycle synchronous memory.
module tb_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;
    logic        deq_pred_taken;
    logic        halted;
    logic [2:0]  occupancy;

    logic [31:0] imem [4096];
    int          n_asserts;
    int          n_fails;

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0),
        .AW       (12)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ce             (ce),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .deq_pc         (deq_pc),
        .deq_instr      (deq_instr),
        .deq_pred_taken (deq_pred_taken),
        .halted         (halted),
        .occupancy      (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program word i is "addi x(i+1), x0, i+1", so 0x00100093, 0x00200113, ...
    initial begin
        for (int i = 0; i < 4096; i++) begin
            imem[i] = {12'(i + 1), 5'd0, 3'd0, 5'(i + 1), 7'h13};
        end
    end

    // Synchronous memory sharing the stage's clock enable.
    always @(posedge clk) begin
        if (ce) imem_rdata <= imem[imem_addr];
    end

    // The credit rule must never let the FIFO grow past DEPTH.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            n_asserts++;
            assert (occupancy <= 3'd4) else begin
                n_fails++;
                $error("[TB] FAIL occupancy_bound: observed %0d expected <= 4", occupancy);
            end
        end
    end

    task automatic applyStimulus(input logic rst_v, input logic ce_v, input logic ready_v,
                                 input logic redir_v, input logic [31:0] rpc_v);
        rst_n       = rst_v;
        ce          = ce_v;
        deq_ready   = ready_v;
        redirect    = redir_v;
        redirect_pc = rpc_v;
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkDeq(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        checkOutput({tag, "_valid"}, 32'(deq_valid), 32'h1);
        checkOutput({tag, "_pc"}, deq_pc, pc);
        checkOutput({tag, "_instr"}, deq_instr, instr);
    endtask

    initial begin
        n_asserts = 0;
        n_fails   = 0;

        // Reset is honoured even with ce low.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        repeat (3) waitCycle();
        checkOutput("rst_imem_req", 32'(imem_req), 32'h0);
        checkOutput("rst_deq_valid", 32'(deq_valid), 32'h0);
        checkOutput("rst_occupancy", 32'(occupancy), 32'h0);
        checkOutput("rst_deq_pc", deq_pc, 32'h0);
        checkOutput("rst_deq_instr", deq_instr, 32'h00000013);
        checkOutput("rst_pred", 32'(deq_pred_taken), 32'h0);
        checkOutput("rst_halted", 32'(halted), 32'h0);

        $display("[TB] startup and streaming");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        waitCycle();
        checkOutput("start_req1", 32'(imem_req), 32'h1);
        checkOutput("start_addr1", 32'(imem_addr), 32'h0);
        checkOutput("start_valid1", 32'(deq_valid), 32'h0);
        waitCycle();
        checkOutput("start_valid2", 32'(deq_valid), 32'h0);
        waitCycle();
        checkDeq("stream_0", 32'h0, 32'h00100093);
        checkOutput("stream_occ", 32'(occupancy), 32'h1);
        waitCycle();
        checkDeq("stream_4", 32'h4, 32'h00200113);
        waitCycle();
        checkDeq("stream_8", 32'h8, 32'h00300193);

        $display("[TB] back-pressure");
        deq_ready = 1'b0;
        waitCycle();
        waitCycle();
        checkOutput("bp_occ3", 32'(occupancy), 32'h3);
        checkOutput("bp_req_off", 32'(imem_req), 32'h0);
        waitCycle();
        checkOutput("bp_occ4", 32'(occupancy), 32'h4);
        waitCycle();
        waitCycle();
        checkOutput("bp_occ4_hold", 32'(occupancy), 32'h4);
        checkOutput("bp_req_hold", 32'(imem_req), 32'h0);
        checkDeq("bp_head", 32'h8, 32'h00300193);
        deq_ready = 1'b1;
        waitCycle();
        checkDeq("resume_c", 32'hC, 32'h00400213);
        waitCycle();
        checkDeq("resume_10", 32'h10, 32'h00500293);
        waitCycle();
        checkDeq("resume_14", 32'h14, 32'h00600313);
        waitCycle();
        checkDeq("resume_18", 32'h18, 32'h00700393);
        waitCycle();
        checkDeq("resume_1c", 32'h1C, 32'h00800413);

        $display("[TB] redirect with occupancy 3 and a response in flight");
        deq_ready = 1'b0;
        waitCycle();
        waitCycle();
        checkOutput("redir_pre_occ", 32'(occupancy), 32'h3);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h43);
        waitCycle();
        checkOutput("redir_occ0", 32'(occupancy), 32'h0);
        checkOutput("redir_valid0", 32'(deq_valid), 32'h0);
        checkOutput("redir_req0", 32'(imem_req), 32'h0);
        redirect = 1'b0;
        waitCycle();
        checkOutput("redir_req1", 32'(imem_req), 32'h1);
        checkOutput("redir_addr", 32'(imem_addr), 32'h10);
        waitCycle();
        checkOutput("redir_stale_dropped", 32'(deq_valid), 32'h0);
        waitCycle();
        checkDeq("redir_40", 32'h40, 32'h01100893);
        waitCycle();
        checkDeq("redir_44", 32'h44, 32'h01200913);

        $display("[TB] halt instruction at 0x0C");
        imem[3] = 32'h000f0033;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0);
        waitCycle();
        checkOutput("halt_flush_occ", 32'(occupancy), 32'h0);
        redirect = 1'b0;
        waitCycle();
        waitCycle();
        waitCycle();
        checkDeq("halt_0", 32'h0, 32'h00100093);
        waitCycle();
        checkDeq("halt_4", 32'h4, 32'h00200113);
        waitCycle();
        checkDeq("halt_8", 32'h8, 32'h00300193);
        checkOutput("halt_not_yet", 32'(halted), 32'h0);
        waitCycle();
        checkDeq("halt_c", 32'hC, 32'h000f0033);
        checkOutput("halt_set", 32'(halted), 32'h1);
        waitCycle();
        checkOutput("halt_no_10", 32'(deq_valid), 32'h0);
        checkOutput("halt_req_off", 32'(imem_req), 32'h0);
        checkOutput("halt_sticky", 32'(halted), 32'h1);
        waitCycle();
        checkOutput("halt_empty", 32'(occupancy), 32'h0);
        imem[3] = 32'h00400213;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0);
        waitCycle();
        checkOutput("halt_cleared", 32'(halted), 32'h0);
        redirect = 1'b0;
        waitCycle();
        waitCycle();
        waitCycle();
        checkDeq("unhalt_0", 32'h0, 32'h00100093);
        waitCycle();
        checkDeq("unhalt_4", 32'h4, 32'h00200113);

        $display("[TB] clock enable freeze");
        ce = 1'b0;
        for (int i = 0; i < 5; i++) begin
            waitCycle();
            checkDeq("freeze", 32'h4, 32'h00200113);
            checkOutput("freeze_occ", 32'(occupancy), 32'h1);
            checkOutput("freeze_req", 32'(imem_req), 32'h1);
            checkOutput("freeze_addr", 32'(imem_addr), 32'h3);
            if (i == 0) begin
                redirect    = 1'b1;
                redirect_pc = 32'h80;
            end
            if (i == 2) redirect = 1'b0;
        end
        ce = 1'b1;
        waitCycle();
        checkDeq("thaw_8", 32'h8, 32'h00300193);
        waitCycle();
        checkDeq("thaw_c", 32'hC, 32'h00400213);
        waitCycle();
        checkDeq("thaw_10", 32'h10, 32'h00500293);

        $display("[TB] backward branch at 0x08");
        imem[2] = 32'hFE000EE3;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0);
        waitCycle();
        redirect = 1'b0;
        waitCycle();
        waitCycle();
        waitCycle();
        checkDeq("br_0", 32'h0, 32'h00100093);
        checkOutput("br_pred0", 32'(deq_pred_taken), 32'h0);
        waitCycle();
        checkDeq("br_4", 32'h4, 32'h00200113);
        waitCycle();
        checkDeq("br_8", 32'h8, 32'hFE000EE3);
`ifdef FETCH_QUEUE_BTFN_EN
        checkOutput("br_pred8", 32'(deq_pred_taken), 32'h1);
        waitCycle();
        checkOutput("br_gap1", 32'(deq_valid), 32'h0);
        waitCycle();
        checkOutput("br_gap2", 32'(deq_valid), 32'h0);
        waitCycle();
        checkDeq("br_target_4", 32'h4, 32'h00200113);
        checkOutput("br_target_pred", 32'(deq_pred_taken), 32'h0);
        waitCycle();
        checkDeq("br_loop_8", 32'h8, 32'hFE000EE3);
        checkOutput("br_loop_pred", 32'(deq_pred_taken), 32'h1);
`else
        checkOutput("br_pred8", 32'(deq_pred_taken), 32'h0);
        waitCycle();
        checkDeq("br_seq_c", 32'hC, 32'h00400213);
        waitCycle();
        checkDeq("br_seq_10", 32'h10, 32'h00500293);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
